// File: rtl/wts_envelope_generator_if.sv
// Channel-side bundle for the ADSR envelope generator: key pulses, rate/level registers, level outputs.
// master = channel control / register file side, slave = envelope generator.
interface wts_envelope_generator_if;
    logic        tick;
    logic        key_on;
    logic        key_release;
    logic        key_off;
    logic [15:0] reg_ar;
    logic [15:0] reg_dr;
    logic [15:0] reg_sr;
    logic [15:0] reg_rr;
    logic [7:0]  reg_sl;
    logic [7:0]  envelope;
    logic [2:0]  env_state;
    logic        env_active;

    modport master (
        output tick, key_on, key_release, key_off,
        output reg_ar, reg_dr, reg_sr, reg_rr, reg_sl,
        input  envelope, env_state, env_active
    );

    modport slave (
        input  tick, key_on, key_release, key_off,
        input  reg_ar, reg_dr, reg_sr, reg_rr, reg_sl,
        output envelope, env_state, env_active
    );
endinterface

// File: rtl/wts_envelope_generator.sv
// Per-channel ADSR envelope: 20-bit level accumulator stepped on tick, key pulses retarget the phase.
// Latency: outputs registered, valid one clk after the key/tick edge.
// No backpressure: key pulses and ticks are consumed the cycle they arrive.
module wts_envelope_generator #(
    parameter int ACC_W = 20
) (
    input  logic                      clk,
    input  logic                      nreset,
    wts_envelope_generator_if.slave   env
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               active_q;

    logic [ACC_W-1:0]   rate;
    logic [ACC_W-1:0]   sus_lvl;
    logic [ACC_W:0]     sum;
    logic [ACC_W:0]     diff;
    logic               key_evt;

    assign key_evt = env.key_off | env.key_on | env.key_release;
    assign sus_lvl = {env.reg_sl, {(ACC_W-8){1'b0}}};

    always_comb begin
        rate = '0;
        case (state_q)
            ST_ATTACK:  rate = {{(ACC_W-16){1'b0}}, env.reg_ar};
            ST_DECAY:   rate = {{(ACC_W-16){1'b0}}, env.reg_dr};
            ST_SUSTAIN: rate = {{(ACC_W-16){1'b0}}, env.reg_sr};
            ST_RELEASE: rate = {{(ACC_W-16){1'b0}}, env.reg_rr};
            default:    rate = '0;
        endcase
    end

    // Bit ACC_W of sum is the overflow, of diff the borrow.
    assign sum  = {1'b0, acc_q} + {1'b0, rate};
    assign diff = {1'b0, acc_q} - {1'b0, rate};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (env.key_off) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end else if (env.key_on) begin
            state_d = ST_ATTACK;
        end else if (env.key_release) begin
            if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)
                state_d = ST_RELEASE;
        end else if (env.tick && !key_evt) begin
            case (state_q)
                ST_ATTACK: begin
                    if (sum[ACC_W]) begin
                        acc_d   = ACC_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
                ST_DECAY: begin
                    // A zero rate still lands on sustain once acc is already at/below the target.
                    if (diff[ACC_W] || diff[ACC_W-1:0] <= sus_lvl) begin
                        acc_d   = sus_lvl;
                        state_d = ST_SUSTAIN;
                    end else begin
                        acc_d = diff[ACC_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    acc_d = diff[ACC_W] ? '0 : diff[ACC_W-1:0];
                end
                ST_RELEASE: begin
                    // Zero release rate parks the level, even at 0.
                    if (rate != '0) begin
                        if (diff[ACC_W] || diff[ACC_W-1:0] == '0) begin
                            acc_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            acc_d = diff[ACC_W-1:0];
                        end
                    end
                end
                default: begin
                    acc_d   = acc_q;
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign env.envelope   = acc_q[ACC_W-1 -: 8];
    assign env.env_state  = state_q;
    assign env.env_active = active_q;
endmodule
